// File: rtl/fpu_seq_pkg.sv
// Shared FP sequencer constants: op codes, latencies, state type.
// Op classification helpers used by the sequencer and the latency LUT.
package fpu_seq_pkg;

  localparam logic [4:0] FOPADD    = 5'd0;
  localparam logic [4:0] FOPSUB    = 5'd1;
  localparam logic [4:0] FOPMUL    = 5'd2;
  localparam logic [4:0] FOPDIV    = 5'd3;
  localparam logic [4:0] FOPSQRT   = 5'd4;
  localparam logic [4:0] FOPABS    = 5'd5;
  localparam logic [4:0] FOPNEG    = 5'd6;
  localparam logic [4:0] FOPSIGNJ  = 5'd7;
  localparam logic [4:0] FOPSIGNJN = 5'd8;
  localparam logic [4:0] FOPSIGNJX = 5'd9;
  localparam logic [4:0] FOPCVTSW  = 5'd10;
  localparam logic [4:0] FOPCVTWS  = 5'd11;
  localparam logic [4:0] FOPCEQ    = 5'd12;
  localparam logic [4:0] FOPCLT    = 5'd13;
  localparam logic [4:0] FOPCLE    = 5'd14;

  localparam int LAT_ADDSUB = 7;
  localparam int LAT_MUL    = 5;
  localparam int LAT_DIV    = 6;
  localparam int LAT_SQRT   = 16;
  localparam int LAT_CVT    = 6;
  localparam int LAT_CMP    = 1;
  localparam int LAT_SIGN   = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_known(logic [4:0] op);
    return op <= FOPCLE;
  endfunction

  function automatic logic op_cmp(logic [4:0] op);
    return (op == FOPCEQ) || (op == FOPCLT) || (op == FOPCLE);
  endfunction

  function automatic logic op_fwr(logic [4:0] op);
    return op_known(op) && !op_cmp(op) && (op != FOPCVTWS);
  endfunction

endpackage

// File: rtl/fpu_seq_lat_lut.sv
// Op code to latency. A 4-bit field cannot hold 16, so 0 encodes
// the 16-cycle square root; the sequencer widens it back.
module fpu_lat_lut
  import fpu_seq_pkg::*;
(
  input  logic [4:0] iop,
  output logic [3:0] olat
);

  function automatic logic [3:0] enc(int l);
    return l[3:0];
  endfunction

  always_comb begin
    olat = enc(LAT_SIGN);
    case (iop)
      FOPADD, FOPSUB:                    olat = enc(LAT_ADDSUB);
      FOPMUL:                            olat = enc(LAT_MUL);
      FOPDIV:                            olat = enc(LAT_DIV);
      FOPSQRT:                           olat = enc(LAT_SQRT);
      FOPCVTSW, FOPCVTWS:                olat = enc(LAT_CVT);
      FOPCEQ, FOPCLT, FOPCLE:            olat = enc(LAT_CMP);
      FOPABS, FOPNEG, FOPSIGNJ,
      FOPSIGNJN, FOPSIGNJX:              olat = enc(LAT_SIGN);
      default:                           olat = enc(LAT_SIGN);
    endcase
  end

endmodule

// File: rtl/fpu_seq.sv
// Issue/wait/capture sequencer around a multi-cycle FP ALU,
// with sticky IEEE exception flags.
module fpu_seq
  import fpu_seq_pkg::*;
(
  input  logic        iclock,
  input  logic        ireset_n,
  input  logic        istart,
  input  logic [4:0]  iop,
  input  logic [31:0] ifrs1,
  input  logic [31:0] ifrs2,
  input  logic        iflush,
  input  logic        iclr_fflags,
  output logic [4:0]  oalu_control,
  output logic [31:0] oalu_dataa,
  output logic [31:0] oalu_datab,
  input  logic [31:0] ialu_result,
  input  logic        ialu_nan,
  input  logic        ialu_zero,
  input  logic        ialu_overflow,
  input  logic        ialu_underflow,
  input  logic        ialu_cmp,
  output logic        obusy,
  output logic        odone,
  output logic [31:0] oresult,
  output logic        ofwrite,
  output logic [4:0]  offlags
);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [4:0]  ctl_q;
  logic [31:0] da_q, db_q, res_q;
  logic        busy_q, done_q, fw_q;
  logic [4:0]  flags_q;

  logic [3:0]  lat;
  logic [4:0]  lat_d;
  logic        cap;
  logic        dz_d, a_nan;
  logic [31:0] res_d;
  logic [4:0]  flags_d;
  logic        alu_zero_unused;

  fpu_lat_lut u_lut (
    .iop  (iop),
    .olat (lat)
  );

  assign lat_d = {lat == 4'd0, lat};
  assign alu_zero_unused = ialu_zero;

  assign cap = (state_q == S_WAIT) && !iflush && (cnt_q == 5'd1);

  assign a_nan = (da_q[30:23] == 8'hff) && (da_q[22:0] != 23'd0);
  assign dz_d  = (ctl_q == FOPDIV) && (db_q[30:0] == 31'd0)
              && (da_q[30:0] != 31'd0) && !a_nan;

  always_comb begin
    res_d   = 32'd0;
    flags_d = 5'd0;
    if (op_known(ctl_q)) begin
      res_d   = op_cmp(ctl_q) ? {31'd0, ialu_cmp} : ialu_result;
      flags_d = {ialu_nan, dz_d, ialu_overflow, ialu_underflow,
                 ialu_overflow | ialu_underflow};
    end
  end

  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      ctl_q   <= 5'd0;
      da_q    <= 32'd0;
      db_q    <= 32'd0;
      res_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fw_q    <= 1'b0;
      flags_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (istart && !iflush) begin
            ctl_q   <= iop;
            da_q    <= ifrs1;
            db_q    <= ifrs2;
            cnt_q   <= lat_d;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (iflush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 5'd0;
          end else if (cnt_q == 5'd1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= 5'd0;
            res_q   <= res_d;
            fw_q    <= op_fwr(ctl_q);
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // a clear landing on a capture keeps only the new flags
      if (iclr_fflags)
        flags_q <= cap ? flags_d : 5'd0;
      else if (cap)
        flags_q <= flags_q | flags_d;
    end
  end

  assign oalu_control = ctl_q;
  assign oalu_dataa   = da_q;
  assign oalu_datab   = db_q;
  assign obusy        = busy_q;
  assign odone        = done_q;
  assign oresult      = res_q;
  assign ofwrite      = fw_q;
  assign offlags      = flags_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Directed and randomized checks of fpu_seq against a behavioural model;
// the bench plays the role of the FP ALU.
module tb_fpu_seq;
  import fpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        clr = 1'b0;
  logic [4:0]  op = 5'd0;
  logic [31:0] a = 32'd0, b = 32'd0, alu_res = 32'd0;
  logic        alu_nan = 1'b0, alu_zero = 1'b0, alu_ov = 1'b0;
  logic        alu_un = 1'b0, alu_cmp = 1'b0;

  logic [4:0]  oalu_control;
  logic [31:0] oalu_dataa, oalu_datab, oresult;
  logic        obusy, odone, ofwrite;
  logic [4:0]  offlags;

  int          ntests = 0;
  int          nfail = 0;
  logic [4:0]  acc = 5'd0;
  logic [31:0] last_res = 32'd0;
  logic        last_fw = 1'b0;

  fpu_seq dut (
    .iclock         (clk),
    .ireset_n       (rst_n),
    .istart         (start),
    .iop            (op),
    .ifrs1          (a),
    .ifrs2          (b),
    .iflush         (flush),
    .iclr_fflags    (clr),
    .oalu_control   (oalu_control),
    .oalu_dataa     (oalu_dataa),
    .oalu_datab     (oalu_datab),
    .ialu_result    (alu_res),
    .ialu_nan       (alu_nan),
    .ialu_zero      (alu_zero),
    .ialu_overflow  (alu_ov),
    .ialu_underflow (alu_un),
    .ialu_cmp       (alu_cmp),
    .obusy          (obusy),
    .odone          (odone),
    .oresult        (oresult),
    .ofwrite        (ofwrite),
    .offlags        (offlags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(logic [4:0] o);
    case (o)
      5'd0, 5'd1:          return 7;
      5'd2:                return 5;
      5'd3:                return 6;
      5'd4:                return 16;
      5'd10, 5'd11:        return 6;
      default:             return 1;
    endcase
  endfunction

  function automatic bit ref_known(logic [4:0] o);
    return int'(o) < 15;
  endfunction

  function automatic bit ref_cmp(logic [4:0] o);
    return o == 5'd12 || o == 5'd13 || o == 5'd14;
  endfunction

  function automatic logic [4:0] ref_flags(logic [4:0] o, logic [31:0] x,
    logic [31:0] y, logic nan, logic ov, logic un);
    bit xnan, dz;
    if (!ref_known(o)) return 5'd0;
    xnan = (x[30:23] == 8'hff) && (x[22:0] != 0);
    dz = (o == 5'd3) && (y[30:0] == 0) && (x[30:0] != 0) && !xnan;
    return {nan, dz, ov, un, ov | un};
  endfunction

  task automatic run_op(input string tag, input logic [4:0] o,
    input logic [31:0] x, input logic [31:0] y, input logic [31:0] r,
    input logic nan, input logic ov, input logic un, input logic cmpv,
    input logic doclr);
    int el;
    int want;
    logic [4:0] nf;
    want = ref_lat(o);
    op = o; a = x; b = y; alu_res = r;
    alu_nan = nan; alu_ov = ov; alu_un = un; alu_cmp = cmpv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, {31'd0, obusy}, 32'd1);
    chk({tag, " ctl"}, {27'd0, oalu_control}, {27'd0, o});
    el = 0;
    for (int k = 1; k <= 24 && el == 0; k++) begin
      clr = doclr && (k == want);
      @(posedge clk); #1;
      clr = 1'b0;
      if (odone) el = k;
    end
    chk({tag, " latency"}, el, want);
    nf = ref_flags(o, x, y, nan, ov, un);
    acc = doclr ? nf : (acc | nf);
    if (!ref_known(o)) last_res = 32'd0;
    else if (ref_cmp(o)) last_res = {31'd0, cmpv};
    else last_res = r;
    last_fw = ref_known(o) && !ref_cmp(o) && o != 5'd11;
    chk({tag, " result"}, oresult, last_res);
    chk({tag, " fwrite"}, {31'd0, ofwrite}, {31'd0, last_fw});
    chk({tag, " flags"}, {27'd0, offlags}, {27'd0, acc});
  endtask

  initial begin
    logic [4:0]  ro;
    logic [31:0] rx, ry;
    int          seen;

    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, obusy}, 32'd0);
    chk("rst done", {31'd0, odone}, 32'd0);
    chk("rst fwrite", {31'd0, ofwrite}, 32'd0);
    chk("rst result", oresult, 32'd0);
    chk("rst ctl", {27'd0, oalu_control}, 32'd0);
    chk("rst dataa", oalu_dataa, 32'd0);
    chk("rst datab", oalu_datab, 32'd0);
    chk("rst flags", {27'd0, offlags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add", FOPADD, 32'h3F800000, 32'h40000000, 32'h40400000,
           0, 0, 0, 0, 0);
    run_op("div0", FOPDIV, 32'h3F800000, 32'h00000000, 32'h7F800000,
           0, 0, 0, 0, 0);
    chk("div0 dz", {27'd0, offlags}, 32'h08);
    run_op("mul", FOPMUL, 32'h40000000, 32'h40400000, 32'h40C00000,
           0, 0, 0, 0, 0);
    chk("mul sticky", {27'd0, offlags}, 32'h08);
    chk("b2b in done", {31'd0, odone}, 32'd1);
    run_op("clt b2b", FOPCLT, 32'h3F800000, 32'h40000000, 32'hDEADBEEF,
           0, 0, 0, 1, 0);
    @(posedge clk); #1;
    chk("done one cycle", {31'd0, odone}, 32'd0);

    // square root flushed mid-flight, with a start pulse ignored in WAIT
    op = FOPSQRT; a = 32'h40800000; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    op = FOPADD; a = 32'h11111111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("wait ign ctl", {27'd0, oalu_control}, {27'd0, FOPSQRT});
    chk("wait ign dataa", oalu_dataa, 32'h40800000);
    chk("wait ign busy", {31'd0, obusy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", {31'd0, obusy}, 32'd0);
    chk("flush result", oresult, last_res);
    chk("flush flags", {27'd0, offlags}, {27'd0, acc});
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (odone) seen++;
    end
    chk("flush no done", seen, 0);
    run_op("add after flush", FOPADD, 32'h40000000, 32'h40000000,
           32'h40800000, 0, 0, 0, 0, 0);

    run_op("mul ovf clr", FOPMUL, 32'h7F000000, 32'h7F000000, 32'h7F800000,
           0, 1, 0, 0, 1);
    chk("clr only new", {27'd0, offlags}, 32'h05);
    run_op("unknown", 5'd20, 32'h12345678, 32'h9ABCDEF0, 32'hCAFEF00D,
           1, 1, 1, 1, 0);
    run_op("sqrt", FOPSQRT, 32'h41100000, 32'h0, 32'h40400000,
           0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      ro = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31))
                               : 5'($urandom_range(0, 14));
      rx = $urandom;
      ry = $urandom;
      if ($urandom % 3 == 0) ry[30:0] = 31'd0;
      if ($urandom % 6 == 0) rx[30:0] = {8'hff, 23'd1};
      run_op("rand", ro, rx, ry, $urandom, ($urandom % 5) == 0,
             ($urandom % 5) == 0, ($urandom % 5) == 0, $urandom % 2 == 1,
             ($urandom % 6) == 0);
      if ($urandom % 2 == 1) begin
        @(posedge clk); #1;
        chk("rand idle done", {31'd0, odone}, 32'd0);
      end
    end

    // reset pulled mid-operation
    op = FOPADD; a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    alu_res = 32'h40000000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, obusy}, 32'd0);
    chk("arst result", oresult, 32'd0);
    chk("arst ctl", {27'd0, oalu_control}, 32'd0);
    chk("arst dataa", oalu_dataa, 32'd0);
    chk("arst flags", {27'd0, offlags}, 32'd0);
    chk("arst fwrite", {31'd0, ofwrite}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (odone || obusy) seen++;
    end
    chk("arst no done", seen, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 Parameters SHALL be none; all latencies come from shared constants (REQ-030).
REQ-002 iclock  in  1  single clock; all state on rising edge.
REQ-003 ireset_n  in  1  reset, asynchronous, active-low.
REQ-004 istart  in  1  request to issue one FP operation.
REQ-005 iop  in  5  FOP* operation code.
REQ-006 ifrs1, ifrs2  in  32  operands (IEEE-754 single / int32 for FOPCVTSW).
REQ-007 iflush  in  1  abort in-flight operation.
REQ-008 iclr_fflags  in  1  clear accumulated exception flags.
REQ-009 oalu_control  out  5  registered op driven to the FP ALU.
REQ-010 oalu_dataa, oalu_datab  out  32  registered operands, held stable to the ALU.
REQ-011 ialu_result  in  32, ialu_nan/ialu_zero/ialu_overflow/ialu_underflow/ialu_cmp  in  1  each: ALU outputs.
REQ-012 obusy  out  1  operation in flight (state WAIT).
REQ-013 odone  out  1  one-cycle completion pulse.
REQ-014 oresult  out  32  captured result.
REQ-015 ofwrite  out  1  result targets FP register file (0 for compares and FOPCVTWS).
REQ-016 offlags  out  5  sticky flags {NV,DZ,OF,UF,NX}, bit 4 down to 0.

Function
REQ-017 States SHALL be IDLE, WAIT, DONE.
REQ-018 istart SHALL be accepted only in IDLE or DONE; at the accepting edge E0 iop/ifrs1/ifrs2 SHALL be latched into oalu_control/oalu_dataa/oalu_datab, the counter SHALL be loaded with LAT(iop), and the state SHALL go to WAIT.
REQ-019 istart in WAIT SHALL be ignored with no side effects.
REQ-020 The counter SHALL decrement once per edge in WAIT; at the edge where it equals 1, ialu_* SHALL be captured, the state SHALL go to DONE, and odone SHALL be asserted, i.e. at edge E0+LAT.
REQ-021 odone SHALL be high for exactly the one DONE cycle; DONE SHALL return to IDLE unless istart is high, which gives back-to-back issue with no idle cycle.
REQ-022 oalu_control/oalu_dataa/oalu_datab SHALL hold their values from E0 until the next accepted istart.
REQ-023 oresult SHALL be {31'b0, ialu_cmp} for FOPCEQ/FOPCLT/FOPCLE and ialu_result otherwise; it holds until the next capture.
REQ-024 Unknown iop SHALL use LAT=1, with oresult=0, no flags, and ofwrite=0.
REQ-025 Flags at capture: NV=ialu_nan; OF=ialu_overflow; UF=ialu_underflow; NX=OF|UF; DZ=1 only for FOPDIV with oalu_datab[30:0]==0 and oalu_dataa[30:0]!=0 and dataa not NaN.
REQ-026 offlags SHALL be ORed with the capture flags at the DONE edge; iclr_fflags SHALL zero it, and if a clear coincides with a capture, offlags SHALL equal the new flags only.
REQ-027 When iflush is high in WAIT, the state SHALL go to IDLE at the next edge, with no odone, no flag update, and oresult unchanged.
REQ-028 iflush in IDLE/DONE SHALL have no effect beyond suppressing a simultaneous istart; flush takes priority over start.

Reset
REQ-029 While ireset_n is low: state IDLE, counter 0, obusy=0, odone=0, ofwrite=0, oresult=0, oalu_control=0, oalu_dataa/oalu_datab=0, offlags=0; reset mid-operation SHALL discard that operation silently.

Structure
REQ-030 FOP* codes and latency constants SHALL live in the shared parameter file Parametros.v: LAT_ADDSUB=7, LAT_MUL=5, LAT_DIV=6, LAT_SQRT=16, LAT_CVT=6 (both directions), LAT_CMP=1, LAT_SIGN=1 (ABS/NEG/SIGNJ*).
REQ-031 A combinational sub-module fpu_lat_lut (iop -> 4-bit latency) SHALL be used; all other logic SHALL be flat.

Verification
REQ-032 FOPADD 0x3F800000+0x40000000 -> odone exactly 7 edges after the accept edge, oresult=0x40400000, ofwrite=1, offlags=0.
REQ-033 FOPDIV 0x3F800000/0x00000000 -> odone at +6, offlags=5'b01000 (DZ); a following FOPMUL 2.0*3.0 -> 0x40C00000 with offlags still 5'b01000.
REQ-034 FOPCLT 1.0<2.0 issued back-to-back in the DONE cycle of a prior op -> no idle cycle, odone at +1, oresult=0x00000001, ofwrite=0.
REQ-035 FOPSQRT started, then iflush at +5 -> no odone; istart at +8 during IDLE accepted normally; istart pulses during WAIT ignored.
REQ-036 FOPMUL 0x7F000000*0x7F000000 with iclr_fflags asserted in the DONE cycle -> offlags=5'b00101 (OF,NX) only.
REQ-037 ireset_n pulled low at +3 of an FOPADD -> all outputs at reset values immediately, no odone after release.
